// File: rtl/zl_uart_pkg.sv
// Shared types and constants for the single-wire register bus master.
package zl_uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_A,
    ST_ADDR,
    ST_GAP,
    ST_START_D,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_GUARD
  } zl_state_e;

  localparam logic [6:0] REG_SIG_HI  = 7'd0;
  localparam logic [6:0] REG_SIG_LO  = 7'd1;
  localparam logic [6:0] REG_SCRATCH = 7'd2;
  localparam logic [6:0] REG_LED     = 7'd3;

  localparam int unsigned GAP_DEF     = 2;
  localparam int unsigned GUARD_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 32;

  // Terminal value of a cycle counter that starts at 0 and runs n cycles.
  function automatic logic [7:0] last_cnt(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/zl_rr_arb2.sv
// Two-way round-robin grant; pointer remembers the last accepted port.
module zl_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  // One-hot grant; on contention the port not served last wins.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    last_d = last_q;
    if (accept_i && (grant_o != 2'b00)) begin
      last_d = grant_o[1];
    end
  end

  // Pointer register; reset state is "port 1 last" so port 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/zl_uart_arb.sv
// Two-port arbiter and bit-serial master for the single-wire register bus.
module zl_uart_arb
  import zl_uart_pkg::*;
#(
  parameter int unsigned GAP     = GAP_DEF,
  parameter int unsigned GUARD   = GUARD_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        busy
);

  localparam logic [7:0] GAP_LAST   = last_cnt(GAP);
  localparam logic [7:0] GUARD_LAST = last_cnt(GUARD);
  localparam logic [7:0] TO_LAST    = last_cnt(TIMEOUT);

  zl_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       port_q, port_d;
  logic [7:0] abyte_q, abyte_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rsh_q, rsh_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       rx_s1_q, rx_s2_q;
  logic [1:0] grant;
  logic       accept;
  logic       tx;

  assign accept = (state_q == ST_IDLE) && (grant != 2'b00);

  zl_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // Two-flop synchroniser for the asynchronous reply line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Next-state, serialiser and completion logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    port_d      = port_q;
    abyte_d     = abyte_q;
    wdata_d     = wdata_q;
    rsh_d       = rsh_q;
    rsp_valid_d = 2'b00;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tx          = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          port_d  = grant[1];
          abyte_d = grant[1] ? {req_addr[13:7], req_we[1]} : {req_addr[6:0], req_we[0]};
          wdata_d = grant[1] ? req_wdata[15:8] : req_wdata[7:0];
          state_d = ST_START_A;
        end
      end
      ST_START_A: begin
        tx      = 1'b0;
        cnt_d   = '0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        tx = abyte_q[~cnt_q[2:0]];
        if (cnt_q == 8'd7) begin
          cnt_d   = '0;
          state_d = abyte_q[0] ? ST_GAP : ST_RWAIT;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_START_D;
        end
      end
      ST_START_D: begin
        tx      = 1'b0;
        cnt_d   = '0;
        state_d = ST_WDATA;
      end
      ST_WDATA: begin
        tx = wdata_q[~cnt_q[2:0]];
        if (cnt_q == 8'd7) begin
          cnt_d       = '0;
          state_d     = ST_GUARD;
          rsp_valid_d = port_q ? 2'b10 : 2'b01;
          err_d       = 1'b0;
        end
      end
      ST_RWAIT: begin
        if (!rx_s2_q) begin
          cnt_d   = '0;
          state_d = ST_RDATA;
        end else if (cnt_q == TO_LAST) begin
          cnt_d       = '0;
          state_d     = ST_GUARD;
          rsp_valid_d = port_q ? 2'b10 : 2'b01;
          err_d       = 1'b1;
          rdata_d     = '0;
        end
      end
      ST_RDATA: begin
        rsh_d = {rsh_q[6:0], rx_s2_q};
        if (cnt_q == 8'd7) begin
          cnt_d       = '0;
          state_d     = ST_GUARD;
          rsp_valid_d = port_q ? 2'b10 : 2'b01;
          err_d       = 1'b0;
          rdata_d     = {rsh_q[6:0], rx_s2_q};
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      port_q      <= 1'b0;
      abyte_q     <= '0;
      wdata_q     <= '0;
      rsh_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      abyte_q     <= abyte_d;
      wdata_q     <= wdata_d;
      rsh_q       <= rsh_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = accept ? grant : 2'b00;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign tx_o      = tx;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zl_uart_arb.sv
// Directed bench for zl_uart_arb: write, read, timeout, reset abort, round robin.
module tb_zl_uart_arb;
  import zl_uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        tx_o;
  logic        rx_i;
  logic        busy;

  int checks = 0;
  int errors = 0;

  zl_uart_arb #(.GAP(2), .GUARD(4), .TIMEOUT(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .tx_o      (tx_o),
    .rx_i      (rx_i),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycles 1..24 of a write accepted on the previous cycle.
  task automatic run_write(input string tag, input int port, input logic [6:0] a,
                           input logic [7:0] d, input bit drop);
    logic [23:0] seq;
    logic [1:0]  oh;
    oh  = (port == 1) ? 2'b10 : 2'b01;
    seq = {1'b0, a, 1'b1, 2'b11, 1'b0, d, 4'hF};
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (drop && i == 1) req_valid = 2'b00;
      chk($sformatf("%s tx c%0d", tag, i), tx_o, seq[24-i]);
      chk($sformatf("%s rsp_valid c%0d", tag, i), rsp_valid, (i == 21) ? oh : 2'b00);
      chk($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
      if (i == 21) chk($sformatf("%s rsp_err", tag), rsp_err, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rbyte;
    logic [1:0] exp_oh;
    int         port;

    rbyte     = 8'hDE;
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rx_i      = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("reset tx", tx_o, 1'b1);
    chk("reset req_ready", req_ready, 2'b00);
    chk("reset rsp_valid", rsp_valid, 2'b00);
    chk("reset rdata", rsp_rdata, 8'h00);
    chk("reset err", rsp_err, 1'b0);
    chk("reset busy", busy, 1'b0);

    // Single write from port 0: addr 2, data 0xA5.
    tick();
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {7'd0, REG_SCRATCH};
    req_wdata = {8'h00, 8'hA5};
    #1;
    chk("wr0 ready", req_ready, 2'b01);
    run_write("wr0", 0, REG_SCRATCH, 8'hA5, 1'b1);
    tick();
    chk("wr0 idle c25", busy, 1'b0);

    // Read from port 1, addr 0; slave replies start + 0xDE.
    tick();
    req_valid = 2'b10;
    req_we    = 2'b00;
    req_addr  = {REG_SIG_HI, 7'd0};
    #1;
    chk("rd1 ready", req_ready, 2'b10);
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1) req_valid = 2'b00;
      if (i == 14)                rx_i = 1'b0;
      else if (i >= 15 && i <= 22) rx_i = rbyte[22-i];
      else                        rx_i = 1'b1;
      chk($sformatf("rd1 tx c%0d", i), tx_o, (i <= 9) ? 1'b0 : 1'b1);
      chk($sformatf("rd1 rsp_valid c%0d", i), rsp_valid, (i == 25) ? 2'b10 : 2'b00);
    end
    chk("rd1 rdata", rsp_rdata, 8'hDE);
    chk("rd1 err", rsp_err, 1'b0);
    repeat (4) tick();
    chk("rd1 idle", busy, 1'b0);

    // Read from port 0 with a silent reply line.
    tick();
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = {7'd0, REG_SIG_LO};
    #1;
    chk("to0 ready", req_ready, 2'b01);
    for (int i = 1; i <= 42; i++) begin
      tick();
      if (i == 1) req_valid = 2'b00;
      chk($sformatf("to0 rsp_valid c%0d", i), rsp_valid, (i == 42) ? 2'b01 : 2'b00);
      if (i == 41) chk("to0 rdata hold", rsp_rdata, 8'hDE);
    end
    chk("to0 err", rsp_err, 1'b1);
    chk("to0 rdata", rsp_rdata, 8'h00);
    repeat (4) tick();
    chk("to0 idle", busy, 1'b0);

    // Write from port 0 aborted by reset in cycle 5.
    tick();
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {7'd0, REG_LED};
    req_wdata = {8'h00, 8'h5A};
    #1;
    chk("ab0 ready", req_ready, 2'b01);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) req_valid = 2'b00;
    end
    reset = 1'b1;
    tick();
    chk("ab0 tx after reset", tx_o, 1'b1);
    chk("ab0 busy after reset", busy, 1'b0);
    reset = 1'b0;
    for (int i = 7; i <= 30; i++) begin
      tick();
      chk($sformatf("ab0 no rsp c%0d", i), rsp_valid, 2'b00);
      chk($sformatf("ab0 tx idle c%0d", i), tx_o, 1'b1);
    end

    // Both ports requesting continuously: grants alternate starting at port 0.
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_addr  = {REG_SCRATCH, REG_LED};
    req_wdata = {8'h81, 8'h3C};
    #1;
    chk("rr ready t0", req_ready, 2'b01);
    for (int t = 0; t < 4; t++) begin
      port = t % 2;
      run_write($sformatf("rr t%0d", t), port, (port == 1) ? REG_SCRATCH : REG_LED,
                (port == 1) ? 8'h81 : 8'h3C, 1'b0);
      if (t == 3) req_valid = 2'b00;
      tick();
      #1;
      exp_oh = (t == 3) ? 2'b00 : ((port == 1) ? 2'b01 : 2'b10);
      chk($sformatf("rr idle t%0d", t), busy, 1'b0);
      chk($sformatf("rr ready after t%0d", t), req_ready, exp_oh);
    end
    tick();
    chk("final idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zl_uart_arb.md
# zl_uart_arb

Two-port round-robin arbiter and serial master for the single-wire register bus. Two on-chip requesters, such as a self-test sequencer and a debug port, issue 7-bit-address byte reads and writes. The block grants one requester at a time, serialises the transaction onto `tx_o` and, for reads, deserialises the reply from `rx_i`. It returns the result or a timeout error to the granted requester. The bus is one bit per clock, MSB first; a start bit is `0`; the idle line is high.

## Interface
Parameters:
- `GAP`, 2: idle-high cycles between the address byte and the write-data start bit (1..15).
- `GUARD`, 4: idle-high cycles after every transaction before the next grant (1..15).
- `TIMEOUT`, 32: read-reply wait limit in cycles (1..255).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 2: per-port request.
- `req_we` in 2: per-port write flag.
- `req_addr` in 14: port n address at `[7n+6:7n]`.
- `req_wdata` in 16: port n write data at `[8n+7:8n]`.
- `req_ready` out 2: one-cycle accept pulse to the granted port.
- `rsp_valid` out 2: one-cycle completion pulse to the granted port.
- `rsp_rdata` out 8: read data, valid with `rsp_valid`; shared by both ports.
- `rsp_err` out 1: timeout flag, valid with `rsp_valid`.
- `tx_o` out 1: serial line to the slave.
- `rx_i` in 1: serial line from the slave, asynchronous.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Reset values:
  - `tx_o`=1; `req_ready`=0; `rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=0; `busy`=0.
  - State IDLE; round-robin pointer set to "port 1 last", so port 0 wins first.
  - `rx_i` synchroniser flops set to 1.
- `rx_i` passes through a 2-flop synchroniser. All references to `rx` below mean the synchronised value.
- Arbitration (IDLE only):
  - If exactly one `req_valid` bit is set, grant that port.
  - If both are set, grant the port not granted last.
  - Assert `req_ready[g]` for that cycle.
  - Latch we, addr and wdata; the address byte is `{addr[6:0], we}`.
  - Update the pointer.
- States and transitions:
  - IDLE: `tx_o`=1. On accept, go to START_A.
  - START_A: `tx_o`=0 for 1 cycle, then ADDR.
  - ADDR: address byte, 8 cycles, MSB first. Then GAP if writing, else RWAIT.
  - GAP: `tx_o`=1 for `GAP` cycles, then START_D.
  - START_D: `tx_o`=0 for 1 cycle, then WDATA.
  - WDATA: write data, 8 cycles, MSB first, then GUARD with `rsp_valid[g]`=1 and `rsp_err`=0.
  - RWAIT: `tx_o`=1; an 8-bit counter counts cycles.
    - `rx`=0 seen → RDATA.
    - Counter reaches `TIMEOUT` with no start bit → GUARD with `rsp_valid[g]`=1, `rsp_err`=1, `rsp_rdata`=0.
  - RDATA: shift `rx` on each of the next 8 cycles, MSB first, then GUARD with `rsp_valid[g]`=1, `rsp_err`=0, `rsp_rdata` = assembled byte.
  - GUARD: `tx_o`=1 for `GUARD` cycles, then IDLE.
- `rsp_rdata` and `rsp_err` hold their values until the next completion.
- Requests arriving while busy wait; `req_valid` must stay high until `req_ready`.
- A `req_valid` drop before accept is legal; no grant is issued.
- A port's inputs are ignored after its accept.
- Reset mid-transaction:
  - `tx_o`=1 and state IDLE on the next edge.
  - No `rsp_valid` is issued for the aborted transaction.
  - The pointer returns to its reset value.

## Timing
- Accept at cycle 0: START_A at 1, address bits at 2-9.
- Write: GAP at 10..9+`GAP`; with default `GAP`=2, start bit at 12, data at 13-20, `rsp_valid` at 21, next accept possible at 25.
- Read: RWAIT begins at cycle 10. If `rx`=0 is first seen at cycle k, data is sampled at k+1..k+8 and `rsp_valid` comes at k+9.
- Timeout: `rsp_valid` with `rsp_err` at cycle 10+`TIMEOUT`.
- Back-to-back: IDLE lasts exactly 1 cycle when a request is pending.

## Structure
- Shared package `zl_uart_pkg`:
  - State enum.
  - Register address constants: SIG_HI=0, SIG_LO=1, SCRATCH=2, LED=3.
  - Defaults for `GAP`, `GUARD` and `TIMEOUT`.
- One sub-module: `zl_rr_arb2`, a 2-way round-robin grant with pointer update on accept.

## Test plan
- Single write from port 0 (addr 2, data 0xA5) → `tx_o` sequence is start, 0x05, 2 idle, start, 0xA5; `rsp_valid[0]` at cycle 21 with `rsp_err`=0.
- Read from port 1 (addr 0); slave model replies start + 0xDE five cycles after the address → `rsp_valid[1]` with `rsp_rdata`=0xDE.
- Read with silent `rx_i` (held 1) → `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0 at cycle 10+32=42.
- Both ports valid continuously → grants alternate 0,1,0,1; each `rsp_valid` goes to its own port; 1-cycle IDLE between transactions.
- `reset` at cycle 5 of a write → `tx_o`=1 next cycle; no `rsp_valid`; port 0 wins a subsequent dual request.
